// File: rtl/mult_div_unit_pkg.sv
// Shared state encoding and constants for the multicycle multiply/divide unit.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DPREA = 3'd1,
        DPREB = 3'd2,
        MITER = 3'd3,
        DITER = 3'd4,
        DFIX  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam int          ITERS   = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/cla_adder.sv
// 32-bit carry-lookahead adder built from 4-bit lookahead groups; overflow is
// the signed overflow of i_a + i_b + i_cin.
module cla_adder (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_ovf
);
    logic [31:0] w_p;
    logic [31:0] w_g;
    logic [31:0] w_c;
    logic [8:0]  w_gc;

    assign w_p     = i_a ^ i_b;
    assign w_g     = i_a & i_b;
    assign w_gc[0] = i_cin;

    for (genvar g = 0; g < 8; g++) begin : g_grp
        logic [3:0] w_gp4;
        logic [3:0] w_gg4;
        logic       w_gp;
        logic       w_gg;

        assign w_gp4 = w_p[4*g +: 4];
        assign w_gg4 = w_g[4*g +: 4];
        assign w_gp  = &w_gp4;
        assign w_gg  = w_gg4[3] | (w_gp4[3] & w_gg4[2]) | (&w_gp4[3:2] & w_gg4[1])
                     | (&w_gp4[3:1] & w_gg4[0]);
        assign w_gc[g+1] = w_gg | (w_gp & w_gc[g]);

        assign w_c[4*g]   = w_gc[g];
        assign w_c[4*g+1] = w_gg4[0] | (w_gp4[0] & w_gc[g]);
        assign w_c[4*g+2] = w_gg4[1] | (w_gp4[1] & w_gg4[0]) | (&w_gp4[1:0] & w_gc[g]);
        assign w_c[4*g+3] = w_gg4[2] | (w_gp4[2] & w_gg4[1]) | (&w_gp4[2:1] & w_gg4[0])
                          | (&w_gp4[2:0] & w_gc[g]);
    end

    assign o_sum = w_p ^ w_c;
    assign o_ovf = w_c[31] ^ w_gc[8];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed 32-bit Booth multiplier / non-restoring divider with a
// one-cycle start pulse and one-cycle ready pulse.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);
    state_t      r_state, w_state_nxt;
    logic [5:0]  r_cnt;
    logic [31:0] r_h, r_l, r_m, r_res;
    logic        r_q, r_sa, r_sb, r_dovf, r_exc;
    logic [32:0] r_r;

    logic        w_start, w_last;
    logic [1:0]  w_booth;
    logic        w_do_op, w_msb, w_ovf;
    logic [31:0] w_sum, w_hs, w_h_nxt, w_l_nxt, w_qfix;
    logic [32:0] w_top, w_rsh, w_rn;

    assign w_start = (r_state == IDLE || r_state == DONE) && (ctrl_MULT || ctrl_DIV);
    assign w_last  = (r_cnt == 6'(ITERS - 1));

    // Booth step: the true sign of the 33-bit add/sub result becomes the shift-in bit.
    assign w_booth = {r_l[0], r_q};
    assign w_do_op = r_l[0] ^ r_q;

    cla_adder u_cla (
        .i_a   (r_h),
        .i_b   ((w_booth == 2'b10) ? ~r_m : r_m),
        .i_cin (w_booth == 2'b10),
        .o_sum (w_sum),
        .o_ovf (w_ovf)
    );

    assign w_hs    = w_do_op ? w_sum : r_h;
    assign w_msb   = w_do_op ? (w_sum[31] ^ w_ovf) : r_h[31];
    assign w_h_nxt = {w_msb, w_hs[31:1]};
    assign w_l_nxt = {w_hs[0], r_l[31:1]};
    assign w_top   = {w_h_nxt, w_l_nxt[31]};

    // Non-restoring divide step; r_l holds the quotient as it shifts in.
    assign w_rsh  = {r_r[31:0], r_l[31]};
    assign w_rn   = r_r[32] ? (w_rsh + {1'b0, r_m}) : (w_rsh - {1'b0, r_m});
    assign w_qfix = (r_sa ^ r_sb) ? -r_l : r_l;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: w_state_nxt = w_start ? (ctrl_MULT ? MITER : DPREA) : IDLE;
            DPREA:      w_state_nxt = DPREB;
            DPREB:      w_state_nxt = DITER;
            MITER:      w_state_nxt = w_last ? DONE : MITER;
            DITER:      w_state_nxt = w_last ? DFIX : DITER;
            DFIX:       w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_h    <= '0;
            r_l    <= '0;
            r_q    <= 1'b0;
            r_m    <= '0;
            r_r    <= '0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_dovf <= 1'b0;
            r_res  <= '0;
            r_exc  <= 1'b0;
        end else if (w_start) begin
            r_cnt  <= '0;
            r_h    <= '0;
            r_l    <= data_operandA;
            r_q    <= 1'b0;
            r_m    <= data_operandB;
            r_r    <= '0;
            r_sa   <= data_operandA[31];
            r_sb   <= data_operandB[31];
            r_dovf <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
        end else begin
            case (r_state)
                DPREA: if (r_sa) r_l <= -r_l;
                DPREB: if (r_sb) r_m <= -r_m;
                MITER: begin
                    r_h   <= w_h_nxt;
                    r_l   <= w_l_nxt;
                    r_q   <= r_l[0];
                    r_cnt <= r_cnt + 6'd1;
                    if (w_last) begin
                        r_res <= w_l_nxt;
                        r_exc <= ~((&w_top) | ~(|w_top));
                    end
                end
                DITER: begin
                    r_r   <= w_rn;
                    r_l   <= {r_l[30:0], ~w_rn[32]};
                    r_cnt <= r_cnt + 6'd1;
                end
                DFIX: begin
                    r_res <= (r_m == '0) ? 32'd0 : (r_dovf ? INT_MIN : w_qfix);
                    r_exc <= (r_m == '0) | r_dovf;
                end
                default: ;
            endcase
        end
    end

    assign data_resultRDY = (r_state == DONE);
    assign data_result    = data_resultRDY ? r_res : '0;
    assign data_exception = data_resultRDY & r_exc;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit: latency, results, exceptions,
// ignored pulses, back-to-back start and asynchronous abort.
module tb_mult_div_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB, data_result;
    logic        data_exception, data_resultRDY;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        mult;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[14];

    mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; the pulse is sampled at the next posedge (cycle 0)
    // and the task returns at the negedge of cycle 1.
    task automatic pulse(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Starts at cycle 1, returns at the negedge of cycle lat with outputs checked.
    task automatic watch(input string nm, input int lat, input logic [31:0] er,
                         input logic ee, input int inj_c);
        logic early = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge clock);
            if (inj_c != 0 && c == inj_c) begin
                ctrl_DIV = 1'b1; data_operandA = 32'd1000; data_operandB = 32'd10;
            end
            if (inj_c != 0 && c == inj_c + 1) ctrl_DIV = 1'b0;
            if (c < lat && (data_resultRDY !== 1'b0 || data_result !== 32'd0)) early = 1'b1;
        end
        chk({nm, " quiet"}, {31'd0, early}, 32'd0);
        chk({nm, " rdy"}, {31'd0, data_resultRDY}, 32'd1);
        chk({nm, " result"}, data_result, er);
        chk({nm, " exc"}, {31'd0, data_exception}, {31'd0, ee});
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
        vecs[1]  = '{1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1};
        vecs[2]  = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[4]  = '{1'b1, 32'd0,          32'd12345,     32'd0,         1'b0};
        vecs[5]  = '{1'b1, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1};
        vecs[7]  = '{1'b0, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 1'b0};
        vecs[8]  = '{1'b0, 32'd100,        32'd7,         32'd14,        1'b0};
        vecs[9]  = '{1'b0, 32'd5,          32'd0,         32'd0,         1'b1};
        vecs[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[11] = '{1'b0, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0};
        vecs[12] = '{1'b0, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         1'b0};
        vecs[13] = '{1'b0, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};

        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        repeat (2) @(negedge clock);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset result", data_result, 32'd0);
        chk("reset exc", {31'd0, data_exception}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 14; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            pulse(vecs[i].mult, ~vecs[i].mult, vecs[i].a, vecs[i].b);
            watch(nm, vecs[i].mult ? 33 : 36, vecs[i].res, vecs[i].exc, 0);
            @(negedge clock);
            chk({nm, " rdy after"}, {31'd0, data_resultRDY}, 32'd0);
            chk({nm, " result after"}, data_result, 32'd0);
        end

        // DIV pulse mid-multiply is ignored; DIV in the DONE cycle starts back-to-back.
        pulse(1'b1, 1'b0, 32'd6, 32'd7);
        watch("mul6x7", 33, 32'd42, 1'b0, 5);
        pulse(1'b0, 1'b1, 32'd84, 32'd2);
        watch("div84/2", 36, 32'd42, 1'b0, 0);
        @(negedge clock);
        chk("b2b rdy after", {31'd0, data_resultRDY}, 32'd0);

        // Asynchronous reset in the middle of cycle 10 aborts the multiply.
        pulse(1'b1, 1'b0, 32'd9, 32'd9);
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("abort result", data_result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        begin
            logic seen = 1'b0;
            for (int c = 11; c <= 40; c++) begin
                if (data_resultRDY !== 1'b0) seen = 1'b1;
                @(negedge clock);
            end
            chk("abort no rdy", {31'd0, seen}, 32'd0);
        end
        pulse(1'b1, 1'b0, 32'd3, 32'd4);
        watch("mul3x4", 33, 32'd12, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
